// File: rtl/enemy_pkg.sv
// Types and constants shared by the enemy block and its inflation controller.
package enemy_pkg;

    typedef enum logic [1:0] {INF_IDLE, INF_INFLATED, INF_POPPED} inflate_state_t;

    localparam logic [7:0] ENEMY_POP_LEVEL = 8'd5;

endpackage

// File: rtl/rise_pulse.sv
// Registered rising-edge detector: one-cycle pulse per low-to-high transition
// of a slow level (e.g. the frame clock) sampled on clk.
module rise_pulse (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic din_delayed_q, din_delayed_d;
    logic pulse_q, pulse_d;

    always_comb begin
        din_delayed_d = din;
        pulse_d       = din & ~din_delayed_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_delayed_q <= 1'b0;
            pulse_q       <= 1'b0;
        end else begin
            din_delayed_q <= din_delayed_d;
            pulse_q       <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/pump_inflate_ctrl.sv
// Per-enemy inflation controller: turns accepted pump strokes into pump_sum,
// deflates over frame ticks when the harpoon is detached, and latches on pop.
module pump_inflate_ctrl
    import enemy_pkg::*;
#(
    parameter logic [7:0] POP_LEVEL       = ENEMY_POP_LEVEL,
    parameter logic [7:0] DEFLATE_FRAMES  = 8'd60,
    parameter logic [7:0] COOLDOWN_FRAMES = 8'd8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       Pump_key,
    input  logic       Enemy_attacked,
    output logic [7:0] pump_sum,
    output logic       Inflated,
    output logic       Enemy_popped,
    output logic       Score_pulse
);

    inflate_state_t state_q, state_d;
    logic [7:0]     pump_sum_q, pump_sum_d;
    logic [7:0]     cooldown_q, cooldown_d;
    logic [7:0]     deflate_cnt_q, deflate_cnt_d;
    logic           inflated_q, inflated_d;
    logic           popped_q, popped_d;
    logic           pop_entry_q, pop_entry_d;
    logic           score_pulse_q, score_pulse_d;
    logic           key_delayed_q, key_delayed_d;
    logic           frame_tick;
    logic           stroke_req;
    logic           stroke_acc;
    logic [7:0]     next_sum;

    rise_pulse u_frame_edge (
        .clk   (Clk),
        .rst   (Reset),
        .din   (frame_clk),
        .pulse (frame_tick)
    );

    assign stroke_req = Pump_key & ~key_delayed_q;
    assign stroke_acc = stroke_req & Enemy_attacked & (cooldown_q == 8'd0)
                      & (state_q != INF_POPPED);

    always_comb begin
        state_d       = state_q;
        pump_sum_d    = pump_sum_q;
        cooldown_d    = cooldown_q;
        deflate_cnt_d = deflate_cnt_q;
        next_sum      = pump_sum_q;
        key_delayed_d = Pump_key;

        if (state_q != INF_POPPED) begin
            if (frame_tick && cooldown_q != 8'd0)
                cooldown_d = cooldown_q - 8'd1;
            // A stroke outranks a deflate step that expires in the same cycle.
            if (stroke_acc) begin
                next_sum      = pump_sum_q + 8'd1;
                pump_sum_d    = next_sum;
                cooldown_d    = COOLDOWN_FRAMES;
                deflate_cnt_d = DEFLATE_FRAMES;
                state_d       = (next_sum >= POP_LEVEL) ? INF_POPPED : INF_INFLATED;
            end else if (state_q == INF_INFLATED && frame_tick && !Enemy_attacked) begin
                if (deflate_cnt_q > 8'd1) begin
                    deflate_cnt_d = deflate_cnt_q - 8'd1;
                end else begin
                    next_sum      = pump_sum_q - 8'd1;
                    pump_sum_d    = next_sum;
                    deflate_cnt_d = DEFLATE_FRAMES;
                    if (next_sum == 8'd0)
                        state_d = INF_IDLE;
                end
            end
        end

        inflated_d    = (pump_sum_d != 8'd0);
        popped_d      = (state_d == INF_POPPED);
        pop_entry_d   = popped_d & (state_q != INF_POPPED);
        score_pulse_d = pop_entry_q;
    end

    always_ff @(posedge Clk) begin
        // The key history keeps following the button through reset so a key
        // held across reset release is not mistaken for a fresh press.
        key_delayed_q <= key_delayed_d;
        if (Reset) begin
            state_q       <= INF_IDLE;
            pump_sum_q    <= 8'd0;
            cooldown_q    <= 8'd0;
            deflate_cnt_q <= DEFLATE_FRAMES;
            inflated_q    <= 1'b0;
            popped_q      <= 1'b0;
            pop_entry_q   <= 1'b0;
            score_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pump_sum_q    <= pump_sum_d;
            cooldown_q    <= cooldown_d;
            deflate_cnt_q <= deflate_cnt_d;
            inflated_q    <= inflated_d;
            popped_q      <= popped_d;
            pop_entry_q   <= pop_entry_d;
            score_pulse_q <= score_pulse_d;
        end
    end

    assign pump_sum     = pump_sum_q;
    assign Inflated     = inflated_q;
    assign Enemy_popped = popped_q;
    assign Score_pulse  = score_pulse_q;

endmodule

// File: tb/tb_pump_inflate_ctrl.sv
// Bench for pump_inflate_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural inflation model.
module tb_pump_inflate_ctrl;

    localparam int POP  = 5;
    localparam int DEF  = 60;
    localparam int COOL = 8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       Pump_key = 1'b0;
    logic       Enemy_attacked = 1'b0;
    logic [7:0] pump_sum;
    logic       Inflated;
    logic       Enemy_popped;
    logic       Score_pulse;

    int checks = 0;
    int failures = 0;
    int score_cnt = 0;

    // behavioural model state
    int m_lvl = 0, m_cd = 0, m_dc = DEF;
    bit m_popped = 0, m_popent = 0, m_score = 0;
    bit m_fprev = 0, m_tick_q = 0, m_kprev = 0;

    pump_inflate_ctrl dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .Pump_key       (Pump_key),
        .Enemy_attacked (Enemy_attacked),
        .pump_sum       (pump_sum),
        .Inflated       (Inflated),
        .Enemy_popped   (Enemy_popped),
        .Score_pulse    (Score_pulse)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: level counter with cooldown and deflate timers, frozen once popped.
    always @(posedge Clk) begin
        bit tick_now, stroke;
        stroke = Pump_key && !m_kprev;
        if (Reset) begin
            m_lvl = 0; m_cd = 0; m_dc = DEF;
            m_popped = 0; m_popent = 0; m_score = 0;
            m_fprev = 0; m_tick_q = 0;
        end else begin
            tick_now = m_tick_q;
            m_tick_q = frame_clk && !m_fprev;
            m_fprev  = frame_clk;
            m_score  = m_popent;
            m_popent = 0;
            if (!m_popped) begin
                if (stroke && Enemy_attacked && m_cd == 0) begin
                    m_lvl = m_lvl + 1;
                    m_cd  = COOL;
                    m_dc  = DEF;
                    if (m_lvl == POP) begin
                        m_popped = 1;
                        m_popent = 1;
                    end
                end else if (tick_now) begin
                    if (m_cd > 0) m_cd = m_cd - 1;
                    if (m_lvl > 0 && !Enemy_attacked) begin
                        if (m_dc > 1) m_dc = m_dc - 1;
                        else begin
                            m_lvl = m_lvl - 1;
                            m_dc  = DEF;
                        end
                    end
                end
            end
        end
        m_kprev = Pump_key;
    end

    // Per-cycle comparison, 1 time unit after the active edge.
    always @(posedge Clk) begin
        #1;
        check("pump_sum", int'(pump_sum), m_lvl);
        check("Inflated", int'(Inflated), int'(m_lvl != 0));
        check("Enemy_popped", int'(Enemy_popped), int'(m_popped));
        check("Score_pulse", int'(Score_pulse), int'(m_score));
        if (Reset) score_cnt = 0;
        else if (Score_pulse) score_cnt++;
    end

    task automatic frames(input int n);
        repeat (n) begin
            @(negedge Clk) frame_clk = 1'b1;
            @(negedge Clk);
            @(negedge Clk) frame_clk = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic stroke();
        @(negedge Clk) Pump_key = 1'b1;
        @(negedge Clk) Pump_key = 1'b0;
    endtask

    task automatic apply_reset(input string tag);
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk);
        check({tag, "_rst_sum"}, int'(pump_sum), 0);
        check({tag, "_rst_infl"}, int'(Inflated), 0);
        check({tag, "_rst_pop"}, int'(Enemy_popped), 0);
        check({tag, "_rst_score"}, int'(Score_pulse), 0);
        Reset = 1'b0;
    endtask

    task automatic pin(input string name, input int exp);
        check({name, "_dut"}, int'(pump_sum), exp);
        check({name, "_model"}, m_lvl, exp);
    endtask

    initial begin
        int fc_cnt;
        int mode;
        repeat (2) @(negedge Clk);
        apply_reset("init");

        // build up to pop with harpoon attached
        Enemy_attacked = 1'b1;
        stroke(); pin("s1", 1);
        check("s1_inflated", int'(Inflated), 1);
        frames(9); stroke(); pin("s2", 2);
        frames(9); stroke(); pin("s3", 3);
        frames(9); stroke(); pin("s4", 4);
        frames(9); stroke(); pin("s5", 5);
        check("pop_flag", int'(Enemy_popped), 1);
        repeat (3) stroke();
        frames(200);
        pin("pop_hold", 5);
        check("score_pulse_count", score_cnt, 1);
        apply_reset("popped");

        // cooldown and detached-harpoon rejection
        Enemy_attacked = 1'b1;
        stroke(); frames(3); stroke(); pin("cooldown", 1);
        frames(9);
        Enemy_attacked = 1'b0;
        stroke(); pin("unattacked", 1);

        // deflate from 2 with harpoon detached
        apply_reset("pre_defl");
        Enemy_attacked = 1'b1;
        stroke(); frames(9); stroke();
        Enemy_attacked = 1'b0;
        frames(60); pin("defl60", 1);
        frames(60); pin("defl120", 0);
        check("defl_inflated", int'(Inflated), 0);

        // attached harpoon holds the level
        apply_reset("pre_hold");
        Enemy_attacked = 1'b1;
        stroke(); frames(9); stroke();
        frames(130); pin("attached_hold", 2);

        // stroke coincident with deflate expiry
        apply_reset("pre_sim");
        Enemy_attacked = 1'b1;
        stroke(); frames(9); stroke();
        Enemy_attacked = 1'b0;
        frames(59);
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) begin Pump_key = 1'b1; Enemy_attacked = 1'b1; end
        @(negedge Clk) begin Pump_key = 1'b0; Enemy_attacked = 1'b0; frame_clk = 1'b0; end
        pin("sim_stroke", 3);
        frames(59); pin("sim_reload59", 3);
        frames(1); pin("sim_reload60", 2);

        // reset mid-deflate
        frames(20);
        apply_reset("mid_defl");

        // key held across reset release
        @(negedge Clk) begin Reset = 1'b1; Pump_key = 1'b1; Enemy_attacked = 1'b1; end
        @(negedge Clk) Reset = 1'b0;
        repeat (4) @(negedge Clk);
        pin("held_key", 0);
        Pump_key = 1'b0;
        @(negedge Clk);
        stroke(); pin("repress", 1);

        // randomized traffic
        fc_cnt = 0;
        mode = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge Clk);
            if (c % 250 == 0) mode = $urandom_range(0, 2);
            Reset = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 3) == 0) Pump_key = ~Pump_key;
            case (mode)
                0: Enemy_attacked = 1'b1;
                1: Enemy_attacked = 1'b0;
                default: Enemy_attacked = ($urandom_range(0, 3) != 0);
            endcase
            if (fc_cnt == 0) begin
                frame_clk = ~frame_clk;
                fc_cnt = $urandom_range(1, 3);
            end else begin
                fc_cnt--;
            end
        end
        Reset = 1'b0;
        repeat (3) @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
